// File: rtl/exe_mul_sequencer_pkg.sv
// Shared definitions for the EXE-stage multiply sequencer: widths, status
// register bit positions, FSM state encoding and the N/Z merge helper.
package exe_mul_sequencer_pkg;

    localparam int WORD_DEFAULT      = 32;
    localparam int STEP_BITS_DEFAULT = 2;

    localparam int SR_N = 3;
    localparam int SR_Z = 2;
    localparam int SR_C = 1;
    localparam int SR_V = 0;

    typedef enum logic [1:0] {
        MUL_IDLE = 2'd0,
        MUL_RUN  = 2'd1,
        MUL_DONE = 2'd2
    } mul_state_e;

    // C and V always pass through; N and Z are replaced only when upd is set.
    function automatic logic [3:0] merge_nz(input logic [3:0] sr, input logic n,
                                            input logic z, input logic upd);
        logic [3:0] out;
        out       = 4'b0000;
        out[SR_N] = upd ? n : sr[SR_N];
        out[SR_Z] = upd ? z : sr[SR_Z];
        out[SR_C] = sr[SR_C];
        out[SR_V] = sr[SR_V];
        return out;
    endfunction

endpackage

// File: rtl/exe_mul_sequencer_if.sv
// Request/response bundle between the EXE stage (master) and the multiply
// sequencer (slave).
interface exe_mul_sequencer_if #(parameter int WORD = 32);

    logic            start;
    logic            acc_en;
    logic            set_flags;
    logic [WORD-1:0] val_Rm;
    logic [WORD-1:0] val_Rs;
    logic [WORD-1:0] val_Rn;
    logic [3:0]      SR_in;
    logic            stall;
    logic            busy;
    logic            done;
    logic [WORD-1:0] result;
    logic [3:0]      status;

    modport master (
        output start, acc_en, set_flags, val_Rm, val_Rs, val_Rn, SR_in,
        input  stall, busy, done, result, status
    );

    modport slave (
        input  start, acc_en, set_flags, val_Rm, val_Rs, val_Rn, SR_in,
        output stall, busy, done, result, status
    );

endinterface

// File: rtl/exe_mul_sequencer_mul_step.sv
// One shift-add step of the iterative multiplier: acc + mcand * slice,
// truncated to WORD bits.
module exe_mul_sequencer_mul_step #(
    parameter int WORD      = 32,
    parameter int STEP_BITS = 2
) (
    input  logic [WORD-1:0]      acc_i,
    input  logic [WORD-1:0]      mcand_i,
    input  logic [STEP_BITS-1:0] slice_i,
    output logic [WORD-1:0]      acc_o
);

    logic [WORD-1:0] slice_ext_s;
    logic [WORD-1:0] prod_s;

    assign slice_ext_s = {{(WORD-STEP_BITS){1'b0}}, slice_i};
    assign prod_s      = mcand_i * slice_ext_s;
    assign acc_o       = acc_i + prod_s;

endmodule

// File: rtl/exe_mul_sequencer.sv
// Multi-cycle MUL/MLA controller for the EXE stage (Rd = Rm*Rs (+Rn)).
// Optional build macro EXE_MUL_EARLY_EXIT_EN ends RUN once the multiplier is exhausted.
module exe_mul_sequencer
    import exe_mul_sequencer_pkg::*;
#(
    parameter int WORD      = WORD_DEFAULT,
    parameter int STEP_BITS = STEP_BITS_DEFAULT
) (
    input  logic                clk,
    input  logic                rst,
    exe_mul_sequencer_if.slave  bus
);

    localparam int N     = WORD / STEP_BITS;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    mul_state_e       state_q, state_d;
    logic [WORD-1:0]  acc_q, acc_d;
    logic [WORD-1:0]  mcand_q, mcand_d;
    logic [WORD-1:0]  mplier_q, mplier_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             flags_q, flags_d;
    logic [3:0]       sr_q, sr_d;
    logic [WORD-1:0]  result_q, result_d;
    logic [3:0]       status_q, status_d;
    logic             done_q, done_d;
    logic [WORD-1:0]  step_acc_s;
    logic             last_step_s;

    exe_mul_sequencer_mul_step #(.WORD(WORD), .STEP_BITS(STEP_BITS)) u_step (
        .acc_i   (acc_q),
        .mcand_i (mcand_q),
        .slice_i (mplier_q[STEP_BITS-1:0]),
        .acc_o   (step_acc_s)
    );

    // Decide whether the current RUN cycle retires the final multiplier slice
    always_comb begin
`ifdef EXE_MUL_EARLY_EXIT_EN
        last_step_s = (count_q == CNT_W'(N - 1)) ||
                      ((mplier_q >> STEP_BITS) == {WORD{1'b0}});
`else
        last_step_s = (count_q == CNT_W'(N - 1));
`endif
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= MUL_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            MUL_IDLE: begin
                if (bus.start) state_d = MUL_RUN;
                else           state_d = MUL_IDLE;
            end
            MUL_RUN: begin
                if (last_step_s) state_d = MUL_DONE;
                else             state_d = MUL_RUN;
            end
            MUL_DONE: state_d = MUL_IDLE;
            default:  state_d = MUL_IDLE;
        endcase
    end

    // FSM outputs: stall has a deliberate combinational path from start
    always_comb begin
        bus.busy  = (state_q == MUL_RUN);
        bus.stall = (state_q == MUL_RUN) || ((state_q == MUL_IDLE) && bus.start);
    end

    // Datapath next-state: operand latch, shift-add step and final capture
    always_comb begin
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        count_d  = count_q;
        flags_d  = flags_q;
        sr_d     = sr_q;
        result_d = result_q;
        status_d = status_q;
        done_d   = 1'b0;
        case (state_q)
            MUL_IDLE: begin
                if (bus.start) begin
                    mcand_d  = bus.val_Rm;
                    mplier_d = bus.val_Rs;
                    acc_d    = bus.acc_en ? bus.val_Rn : {WORD{1'b0}};
                    flags_d  = bus.set_flags;
                    sr_d     = bus.SR_in;
                    count_d  = {CNT_W{1'b0}};
                end else begin
                    count_d = count_q;
                end
            end
            MUL_RUN: begin
                acc_d    = step_acc_s;
                mcand_d  = mcand_q << STEP_BITS;
                mplier_d = mplier_q >> STEP_BITS;
                count_d  = count_q + CNT_W'(1);
                // Outputs are captured on the edge entering DONE so they are valid with done
                if (last_step_s) begin
                    result_d = step_acc_s;
                    status_d = merge_nz(sr_q, step_acc_s[WORD-1],
                                        step_acc_s == {WORD{1'b0}}, flags_q);
                    done_d   = 1'b1;
                end else begin
                    done_d = 1'b0;
                end
            end
            MUL_DONE: done_d = 1'b0;
            default:  done_d = 1'b0;
        endcase
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= {WORD{1'b0}};
            mcand_q  <= {WORD{1'b0}};
            mplier_q <= {WORD{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            flags_q  <= 1'b0;
            sr_q     <= 4'b0000;
            result_q <= {WORD{1'b0}};
            status_q <= 4'b0000;
            done_q   <= 1'b0;
        end else begin
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            count_q  <= count_d;
            flags_q  <= flags_d;
            sr_q     <= sr_d;
            result_q <= result_d;
            status_q <= status_d;
            done_q   <= done_d;
        end
    end

    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.status = status_q;

endmodule

// File: tb/tb_exe_mul_sequencer.sv
// Directed self-checking bench for exe_mul_sequencer; latencies are counted
// in clock edges after the edge that accepts start (16 RUN cycles by default).
module tb_exe_mul_sequencer;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_bad;

    exe_mul_sequencer_if #(.WORD(32)) bus ();

    exe_mul_sequencer dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                          input logic acc, input logic sf, input logic [3:0] sr);
        bus.val_Rm    = rm;
        bus.val_Rs    = rs;
        bus.val_Rn    = rn;
        bus.acc_en    = acc;
        bus.set_flags = sf;
        bus.SR_in     = sr;
    endtask

    // Pulse start for one edge and wait for done; counts stall/busy errors on the way
    task automatic run_op(input logic [31:0] rm, input logic [31:0] rs, input logic [31:0] rn,
                          input logic acc, input logic sf, input logic [3:0] sr,
                          output int lat, output int stall_bad);
        set_op(rm, rs, rn, acc, sf, sr);
        bus.start = 1'b1;
        #1;
        stall_bad = (bus.stall !== 1'b1 || bus.busy !== 1'b0) ? 1 : 0;
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            if (bus.stall !== 1'b1 || bus.busy !== 1'b1) stall_bad++;
            tick();
            lat++;
        end
        if (bus.stall !== 1'b0 || bus.busy !== 1'b0) stall_bad++;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.start = 1'b0;
        set_op(32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 4'b0000);
        tick();
        tick();
        n_cmp++;
        if ({bus.done, bus.busy, bus.stall} !== 3'b000) begin
            $display("FAIL reset_ctrl: got %b expected 000", {bus.done, bus.busy, bus.stall});
            n_bad++;
        end
        n_cmp++;
        if (bus.result !== 32'd0 || bus.status !== 4'b0000) begin
            $display("FAIL reset_data: got result=%h status=%b expected 0/0000", bus.result, bus.status);
            n_bad++;
        end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_mul_basic();
        int lat, sb;
        run_op(32'd7, 32'd6, 32'd99, 1'b0, 1'b1, 4'b0011, lat, sb);
        n_cmp++;
        if (lat !== 16) begin
            $display("FAIL mul_latency: got %0d edges expected 16", lat);
            n_bad++;
        end
        n_cmp++;
        if (bus.result !== 32'd42 || bus.status !== 4'b0011) begin
            $display("FAIL mul_7x6: got %h/%b expected 0000002a/0011", bus.result, bus.status);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.result !== 32'd42) begin
            $display("FAIL done_pulse: got done=%b result=%h expected 0/0000002a", bus.done, bus.result);
            n_bad++;
        end
    endtask

    task automatic test_mla_wrap();
        int lat, sb;
        run_op(32'hFFFF_FFFF, 32'd2, 32'd5, 1'b1, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'h0000_0003 || lat !== 16) begin
            $display("FAIL mla_wrap: got %h lat=%0d expected 00000003 lat=16", bus.result, lat);
            n_bad++;
        end
        n_cmp++;
        if (sb !== 0) begin
            $display("FAIL stall_profile: got %0d bad cycles expected 0", sb);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_flags();
        int lat, sb;
        run_op(32'h8000_0000, 32'd1, 32'd0, 1'b0, 1'b1, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'h8000_0000 || bus.status !== 4'b1000) begin
            $display("FAIL flag_n: got %h/%b expected 80000000/1000", bus.result, bus.status);
            n_bad++;
        end
        tick();
        run_op(32'd0, 32'h1234, 32'd0, 1'b0, 1'b0, 4'b0101, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd0 || bus.status !== 4'b0101) begin
            $display("FAIL flag_nos: got %h/%b expected 00000000/0101", bus.result, bus.status);
            n_bad++;
        end
        tick();
        run_op(32'd0, 32'd5, 32'd0, 1'b0, 1'b1, 4'b1001, lat, sb);
        n_cmp++;
        if (bus.status !== 4'b0101) begin
            $display("FAIL flag_z: got %b expected 0101", bus.status);
            n_bad++;
        end
        tick();
        run_op(32'h0000_FFFF, 32'h0000_FFFF, 32'd0, 1'b0, 1'b1, 4'b0010, lat, sb);
        n_cmp++;
        if (bus.result !== 32'hFFFE_0001 || bus.status !== 4'b1010) begin
            $display("FAIL mul_ffff: got %h/%b expected fffe0001/1010", bus.result, bus.status);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int lat, pulses;
        set_op(32'd3, 32'd5, 32'd0, 1'b0, 1'b0, 4'b0000);
        bus.start = 1'b1;
        tick();
        set_op(32'd9, 32'd9, 32'd0, 1'b0, 1'b0, 4'b0000);
        lat = 0;
        pulses = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (bus.result !== 32'd15 || lat !== 16) begin
            $display("FAIL held_start: got %h lat=%0d expected 0000000f lat=16", bus.result, lat);
            n_bad++;
        end
        tick();
        n_cmp++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.stall !== 1'b1) begin
            $display("FAIL after_done: got done=%b busy=%b stall=%b expected 0 0 1",
                     bus.done, bus.busy, bus.stall);
            n_bad++;
        end
        tick();
        bus.start = 1'b0;
        lat = 0;
        while (bus.done !== 1'b1 && lat < 40) begin
            tick();
            lat++;
        end
        n_cmp++;
        if (bus.result !== 32'd81 || lat !== 16) begin
            $display("FAIL second_op: got %h lat=%0d expected 00000051 lat=16", bus.result, lat);
            n_bad++;
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            $display("FAIL extra_done: got %0d pulses expected 0", pulses);
            n_bad++;
        end
    endtask

    task automatic test_abort();
        int lat, sb, pulses;
        set_op(32'd7, 32'd6, 32'd0, 1'b0, 1'b1, 4'b1111);
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        n_cmp++;
        if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.result !== 32'd0 || bus.status !== 4'b0000) begin
            $display("FAIL abort_state: got busy=%b done=%b result=%h status=%b expected 0 0 0 0000",
                     bus.busy, bus.done, bus.result, bus.status);
            n_bad++;
        end
        pulses = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (bus.done === 1'b1) pulses++;
        end
        n_cmp++;
        if (pulses !== 0) begin
            $display("FAIL abort_done: got %0d pulses expected 0", pulses);
            n_bad++;
        end
        run_op(32'd11, 32'd13, 32'd0, 1'b0, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd143 || lat !== 16) begin
            $display("FAIL after_abort: got %h lat=%0d expected 0000008f lat=16", bus.result, lat);
            n_bad++;
        end
        tick();
    endtask

    task automatic test_early_exit();
        int lat, sb;
`ifdef EXE_MUL_EARLY_EXIT_EN
        run_op(32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd15 || lat !== 1) begin
            $display("FAIL ee_rs3: got %h lat=%0d expected 0000000f lat=1", bus.result, lat);
            n_bad++;
        end
        tick();
        run_op(32'd5, 32'd0, 32'd77, 1'b1, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd77 || lat !== 1) begin
            $display("FAIL ee_rs0: got %h lat=%0d expected 0000004d lat=1", bus.result, lat);
            n_bad++;
        end
        tick();
        run_op(32'd1, 32'h8000_0000, 32'd0, 1'b0, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'h8000_0000 || lat !== 16) begin
            $display("FAIL ee_msb: got %h lat=%0d expected 80000000 lat=16", bus.result, lat);
            n_bad++;
        end
        tick();
`else
        run_op(32'd5, 32'd3, 32'd0, 1'b0, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd15 || lat !== 16) begin
            $display("FAIL full_rs3: got %h lat=%0d expected 0000000f lat=16", bus.result, lat);
            n_bad++;
        end
        tick();
        run_op(32'd5, 32'd0, 32'd77, 1'b1, 1'b0, 4'b0000, lat, sb);
        n_cmp++;
        if (bus.result !== 32'd77 || lat !== 16) begin
            $display("FAIL full_rs0: got %h lat=%0d expected 0000004d lat=16", bus.result, lat);
            n_bad++;
        end
        tick();
`endif
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_mul_basic();
        test_mla_wrap();
        test_flags();
        test_back_to_back();
        test_abort();
        test_early_exit();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
